// File: rtl/cla_multiword_seq_ctrl.sv
// Multi-word adder sequencer: one WIDTH-bit carry-lookahead slice reused WORDS times,
// least-significant word first, with the inter-word carry held in a register.
module cla_multiword_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4,
  localparam int N = WIDTH * WORDS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N:1]   A,
  input  logic [N:1]   B,
  input  logic         CIN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [N:1]   SUM,
  output logic         COUT
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [N:1]       a_q, a_d, b_q, b_d;
  logic [N:1]       sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH:1]   slice_a, slice_b, slice_sum;
  logic             slice_cout;

  // Word select for the shared slice; idx never exceeds WORDS-1.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        slice_a = a_q[w*WIDTH+1 +: WIDTH];
        slice_b = b_q[w*WIDTH+1 +: WIDTH];
      end
    end
  end

  CLA_p_v #(.SIZE(WIDTH)) u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .CIN  (carry_q),
    .SUM  (slice_sum),
    .COUT (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IDX_W'(w)) sum_d[w*WIDTH+1 +: WIDTH] = slice_sum;
        end
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Outputs come straight from flops.
  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
endmodule

// SIZE-bit carry-lookahead adder built from 4-bit lookahead blocks, block carry chained.
module CLA_p_v #(
  parameter int SIZE = 16
) (
  input  logic [SIZE:1] A,
  input  logic [SIZE:1] B,
  input  logic          CIN,
  output logic [SIZE:1] SUM,
  output logic          COUT
);
  localparam int NBLK = SIZE / 4;

  logic [NBLK:0] blk_c;
  assign blk_c[0] = CIN;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    cla_blk4 u_blk (
      .a    (A[i*4+1 +: 4]),
      .b    (B[i*4+1 +: 4]),
      .cin  (blk_c[i]),
      .sum  (SUM[i*4+1 +: 4]),
      .cout (blk_c[i+1])
    );
  end

  assign COUT = blk_c[NBLK];
endmodule

// 4-bit lookahead block: all internal carries and the block carry from p/g terms.
module cla_blk4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p, g, c;
  logic       grp_g, grp_p;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign grp_p = &p;

  assign sum  = p ^ c;
  assign cout = grp_g | (grp_p & cin);
endmodule

// File: tb/tb_cla_multiword_seq_ctrl.sv
// Directed bench for the multi-word adder sequencer (WIDTH=16, WORDS=4).
module tb_cla_multiword_seq_ctrl;
  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int N = WIDTH * WORDS;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID, IN_READY, CIN, OUT_VALID, OUT_READY, COUT;
  logic [N:1]   A, B, SUM;

  int n_run = 0;
  int n_fail = 0;

  cla_multiword_seq_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .COUT      (COUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operand set for a single accept edge, then scramble the inputs.
  task automatic start_add(input logic [N:1] a, input logic [N:1] b, input logic c);
    @(negedge CLK);
    A = a; B = b; CIN = c; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; CIN = ~c;
  endtask

  // Called on the first negedge after the accept edge; returns cycles until OUT_VALID.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!OUT_VALID && cyc < 20) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic add_chk(input string tag, input logic [N:1] a, input logic [N:1] b,
                         input logic c, input logic [N:1] esum, input logic ecout);
    int cyc;
    start_add(a, b, c);
    chk({tag, "_busy"}, {64'd0, IN_READY}, 65'd0);
    wait_done(cyc);
    chk({tag, "_lat"}, 65'(cyc), 65'(WORDS));
    chk({tag, "_sum"}, {COUT, SUM}, {ecout, esum});
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk({tag, "_drain"}, {63'd0, OUT_VALID, IN_READY}, 65'b01);
  endtask

  initial begin
    int cyc, t, rise1, rise2;
    logic prev_v;
    logic [64:0] r1, r2;
    logic [64:0] held;

    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0; CIN = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out", {COUT, SUM}, 65'd0);
    chk("rst_flags", {63'd0, OUT_VALID, IN_READY}, 65'b01);

    add_chk("carry_word", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
    add_chk("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    add_chk("mixed", 64'h3A5C_0C3B_BB4C_D5AC, 64'hCCA5_44F4_5C4A_4A33, 1'b1,
            64'h0701_5130_1797_1FE0, 1'b1);
    add_chk("max_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    add_chk("zero", 64'h0, 64'h0, 1'b0, 64'h0, 1'b0);

    // Backpressure: hold in DONE with stray IN_VALID pulses.
    start_add(64'h1, 64'h2, 1'b0);
    wait_done(cyc);
    chk("bp_lat", 65'(cyc), 65'(WORDS));
    held = {COUT, SUM};
    chk("bp_val", held, 65'h3);
    for (int i = 0; i < 3; i++) begin
      A = 64'h5555; B = 64'h7777; IN_VALID = (i != 1);
      @(negedge CLK);
      chk("bp_hold", {COUT, SUM}, 65'h3);
      chk("bp_flags", {63'd0, OUT_VALID, IN_READY}, 65'b10);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    chk("bp_release", {63'd0, OUT_VALID, IN_READY}, 65'b01);
    chk("bp_keep", {COUT, SUM}, 65'h3);

    // Back-to-back with inputs changed during RUN.
    rise1 = -1; rise2 = -1; r1 = '0; r2 = '0; prev_v = 1'b0;
    @(negedge CLK);
    A = 64'h0000_0000_0000_FFFF; B = 64'h1; CIN = 1'b0;
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    for (t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (t == 0) begin
        A = 64'h1234_5678_9ABC_DEF0; B = 64'h1111_1111_1111_1111;
      end
      if (OUT_VALID && !prev_v) begin
        if (rise1 < 0) begin rise1 = t; r1 = {COUT, SUM}; end
        else if (rise2 < 0) begin rise2 = t; r2 = {COUT, SUM}; end
      end
      prev_v = OUT_VALID;
    end
    IN_VALID = 1'b0;
    chk("b2b_first", r1, 65'h0_0000_0000_0001_0000);
    chk("b2b_second", r2, 65'h0_2345_6789_ABCD_F001);
    chk("b2b_gap", 65'(rise2 - rise1), 65'(WORDS + 2));
    cyc = 0;
    while (!IN_READY && cyc < 20) begin @(negedge CLK); cyc++; end
    chk("b2b_idle", {64'd0, IN_READY}, 65'd1);
    OUT_READY = 1'b0;

    // Reset mid-RUN discards the operation.
    start_add(64'hDEAD_BEEF_0000_0001, 64'h1, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_run_out", {COUT, SUM}, 65'd0);
    chk("rst_run_flags", {63'd0, OUT_VALID, IN_READY}, 65'b01);
    repeat (6) @(negedge CLK);
    chk("rst_run_stay", {63'd0, OUT_VALID, IN_READY}, 65'b01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
